// File: rtl/noc_types_pkg.sv
// rtl/noc_types_pkg.sv - shared NoC flit types and flit-count helper
package noc_types;

    localparam int FLIT_DATA_WIDTH = 8;
    localparam int HDR_FREE_WIDTH  = 4;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        DATA   = 2'd1,
        TAIL   = 2'd2
    } flit_type;

    typedef struct packed {
        logic [FLIT_DATA_WIDTH-HDR_FREE_WIDTH-1:0] dest;
        logic [HDR_FREE_WIDTH-1:0]                 free;
    } flit_hdr_t;

    typedef struct packed {
        flit_type                   ftype;
        logic [FLIT_DATA_WIDTH-1:0] payload;
    } flit_t;

    // Serialiser and deserialiser both size the payload stream with this.
    function automatic int n_flits(input int bits);
        return (bits + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/node_port.sv
// rtl/node_port.sv - flit link between a node and the NoC
interface node_port;
    import noc_types::*;

    flit_t flit;
    logic  enable;
    logic  ack;
    logic  rej;

    modport up   (output flit, output enable, input ack, input rej);
    modport down (input flit, input enable, output ack, output rej);

endinterface

// File: rtl/noc_serial_transmitter.sv
// rtl/noc_serial_transmitter.sv - serialises one local packet into a HEADER/DATA/TAIL flit stream
module noc_serial_transmitter
    import noc_types::*;
#(
    parameter int PACKET_BITS  = 16,
    parameter int PADDING_BITS = 0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           abort,
    input  logic                                           valid,
    output logic                                           ready,
    input  flit_hdr_t                                      hdr,
    input  logic [((PADDING_BITS > 0) ? PADDING_BITS : 1)-1:0] padding,
    input  logic [PACKET_BITS-1:0]                         packet,
    output logic                                           busy,
    output logic                                           done,
    node_port.up                                           up
);

    localparam int N_FLITS = n_flits(PACKET_BITS);
    localparam int DW      = N_FLITS * FLIT_DATA_WIDTH;
    localparam int CW      = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_FLITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    flit_hdr_t             hdr_q, hdr_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  done_q, done_d;
    logic [HDR_FREE_WIDTH-1:0] free_ext;
    logic [FLIT_DATA_WIDTH-1:0] slice;
    logic                  last_slice;

    assign free_ext   = (PADDING_BITS > 0) ? HDR_FREE_WIDTH'(padding) : '0;
    assign slice      = data_q[int'(cnt_q) * FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    assign last_slice = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        hdr_d      = hdr;
                        hdr_d.free = free_ext;
                        data_d     = DW'(packet);
                        cnt_d      = '0;
                        state_d    = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (up.rej) begin
                        cnt_d = '0;
                    end else if (up.ack) begin
                        cnt_d   = '0;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A reject anywhere in the packet restarts from the header.
                    if (up.rej) begin
                        cnt_d   = '0;
                        state_d = ST_HEADER;
                    end else if (up.ack) begin
                        if (last_slice) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        up.enable = 1'b0;
        up.flit   = '0;
        unique case (state_q)
            ST_HEADER: begin
                up.enable       = 1'b1;
                up.flit.ftype   = HEADER;
                up.flit.payload = hdr_q;
            end
            ST_SEND: begin
                up.enable       = 1'b1;
                up.flit.ftype   = last_slice ? TAIL : DATA;
                up.flit.payload = slice;
            end
            default: ;
        endcase
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_noc_serial_transmitter.sv
// tb/tb_noc_serial_transmitter.sv - self-checking bench for noc_serial_transmitter
module tb_noc_serial_transmitter;
    import noc_types::*;

    localparam int PB = 16;
    localparam int NF = (PB + 8 - 1) / 8;

    logic        clk = 1'b0;
    logic        rst_n, abort, valid;
    logic        ready, busy, done;
    flit_hdr_t   hdr;
    logic [3:0]  padding;
    logic [15:0] packet;

    int checks = 0;
    int errors = 0;

    node_port link();

    noc_serial_transmitter #(.PACKET_BITS(PB), .PADDING_BITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (abort),
        .valid   (valid),
        .ready   (ready),
        .hdr     (hdr),
        .padding (padding),
        .packet  (packet),
        .busy    (busy),
        .done    (done),
        .up      (link)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(input flit_type t, input logic [7:0] p);
        flit_t f;
        f.ftype   = t;
        f.payload = p;
        return f;
    endfunction

    function automatic void build(input logic [15:0] pkt, input logic [3:0] pad,
                                  input logic [3:0] dst, inout flit_t q[$]);
        flit_hdr_t h;
        h.dest = dst;
        h.free = pad;
        q.push_back(mk(HEADER, h));
        for (int k = 0; k < NF; k++)
            q.push_back(mk((k == NF - 1) ? TAIL : DATA, 8'((pkt >> (8 * k)) & 16'hFF)));
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_enable"}, 32'(link.enable), 32'd0);
        check({tag, "_ready"},  32'(ready),       32'd1);
        check({tag, "_busy"},   32'(busy),        32'd0);
    endtask

    task automatic run_packet(input logic [15:0] pkt, input logic [3:0] pad, input logic [3:0] dst,
                              input int stall_at, input int stall_len, input int stall_pct,
                              input int rej_at, output int cycles);
        flit_t exp_q[$];
        int    idx;
        int    stall_cnt;
        bit    rej_used;
        bit    finished;
        logic  a, r;
        build(pkt, pad, dst, exp_q);
        check("ready_before_accept", 32'(ready), 32'd1);
        packet   = pkt;
        padding  = pad;
        hdr.dest = dst;
        hdr.free = 4'($urandom);
        valid    = 1'b1;
        tick();
        valid    = 1'b0;
        packet   = 16'($urandom);
        padding  = 4'($urandom);
        hdr      = flit_hdr_t'($urandom);
        idx = 0; cycles = 0; stall_cnt = 0; rej_used = 0; finished = 0;
        while (!finished && cycles < 100) begin
            if (idx == exp_q.size()) begin
                check("done_pulse", 32'(done),        32'd1);
                check("done_ready", 32'(ready),       32'd1);
                check("done_enable", 32'(link.enable), 32'd0);
                finished = 1;
            end else begin
                check("flit_enable", 32'(link.enable), 32'd1);
                check("flit_busy",   32'(busy),        32'd1);
                check("flit_nodone", 32'(done),        32'd0);
                check("flit_value",  32'(link.flit),   32'(exp_q[idx]));
                a = 1'b1;
                r = 1'b0;
                if (idx == stall_at && stall_cnt < stall_len) begin
                    a = 1'b0;
                    stall_cnt++;
                end else if ($urandom_range(99) < stall_pct) begin
                    a = 1'b0;
                end
                if (idx == rej_at && !rej_used) begin
                    r = 1'b1;
                    rej_used = 1;
                end
                link.ack = a;
                link.rej = r;
                tick();
                cycles++;
                link.ack = 1'b0;
                link.rej = 1'b0;
                if (r) idx = 0;
                else if (a) idx++;
            end
        end
        if (!finished) check("packet_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int    cyc;
        flit_t exp_q[$];
        flit_t obs_q[$];
        int    dones;
        logic [15:0] rp;

        rst_n = 1'b0; abort = 1'b0; valid = 1'b0;
        hdr = '0; padding = '0; packet = '0;
        link.ack = 1'b0; link.rej = 1'b0;
        tick(); tick();
        check("rst_enable", 32'(link.enable), 32'd0);
        check("rst_flit",   32'(link.flit),   32'd0);
        check("rst_ready",  32'(ready),       32'd1);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle_checks("idle");
        end

        run_packet(16'hA5C3, 4'h9, 4'h3, -1, 0, 0, -1, cyc);
        check("basic_latency", 32'(cyc), 32'd3);
        tick();
        check("basic_done_once", 32'(done), 32'd0);

        run_packet(16'hA5C3, 4'h9, 4'h3, 1, 3, 0, -1, cyc);
        check("backpressure_latency", 32'(cyc), 32'd6);
        tick();

        run_packet(16'hA5C3, 4'h6, 4'hA, -1, 0, 0, 2, cyc);
        check("reject_latency", 32'(cyc), 32'd6);
        tick();
        check("reject_done_once", 32'(done), 32'd0);

        packet = 16'hBEEF; padding = 4'h1; hdr = '0; valid = 1'b1;
        tick();
        valid = 1'b0; link.ack = 1'b1;
        tick();
        link.ack = 1'b0;
        check("abort_pre_flit", 32'(link.flit), 32'(mk(DATA, 8'hEF)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_checks("abort");
        check("abort_flit", 32'(link.flit), 32'd0);
        check("abort_nodone", 32'(done), 32'd0);
        tick();
        check("abort_nodone_late", 32'(done), 32'd0);

        valid = 1'b1; abort = 1'b1;
        check("abort_valid_ready", 32'(ready), 32'd1);
        tick();
        valid = 1'b0; abort = 1'b0;
        idle_checks("abort_valid");

        packet = 16'h5555; valid = 1'b1;
        tick();
        valid = 1'b0; link.ack = 1'b1;
        tick();
        link.ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        idle_checks("async_rst");
        check("async_rst_flit", 32'(link.flit), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check("async_rst_nodone", 32'(done), 32'd0);
        run_packet(16'h1234, 4'h0, 4'h5, -1, 0, 0, -1, cyc);
        check("post_rst_latency", 32'(cyc), 32'd3);
        tick();

        hdr.dest = 4'h7; hdr.free = 4'hF; padding = 4'h2;
        build(16'h1111, 4'h2, 4'h7, exp_q);
        build(16'h2222, 4'h2, 4'h7, exp_q);
        packet = 16'h1111; valid = 1'b1;
        tick();
        packet = 16'h2222; link.ack = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (link.enable) obs_q.push_back(link.flit);
            if (done) dones++;
            if (i == 3) check("b2b_first_done", 32'(done), 32'd1);
            if (i == 4) check("b2b_second_header", 32'(link.flit), 32'(exp_q[3]));
            tick();
            if (i == 3) valid = 1'b0;
        end
        link.ack = 1'b0;
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_flit_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("b2b_flit", 32'(obs_q[i]), 32'(exp_q[i]));
        tick();
        idle_checks("b2b_end");

        for (int n = 0; n < 8; n++) begin
            rp = 16'($urandom);
            run_packet(rp, 4'($urandom), 4'($urandom), -1, 0, 30,
                       int'($urandom_range(3)) - 1, cyc);
            tick();
            check("rand_done_once", 32'(done), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
